// File: rtl/beta_prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : beta_prefetch_fetch_unit
// Brief    : Pipelined imem fetch unit with a credit-limited prefetch FIFO.
//            Optional same-cycle response bypass: define BETA_FU_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module beta_prefetch_fetch_unit #(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          FifoDepth      = 4,
  parameter int unsigned          MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] BootAddr       = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_en_i,
  input  logic                 flush_i,
  input  logic [AddrWidth-1:0] flush_addr_i,
  output logic                 instr_req_o,
  output logic [AddrWidth-1:0] instr_addr_o,
  input  logic                 instr_ready_i,
  input  logic                 instr_valid_i,
  input  logic [DataWidth-1:0] instr_rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_instr_o,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic                 busy_o
);

  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned AqPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [AddrWidth-1:0] PcStep   = AddrWidth'(DataWidth / 8);
  localparam logic [CntW-1:0]      MaxOut   = CntW'(MaxOutstanding);
  localparam logic [SumW-1:0]      DepthSum = SumW'(FifoDepth);
  localparam logic [AqPtrW-1:0]    AqLast   = AqPtrW'(MaxOutstanding - 1);

  typedef enum logic [0:0] {StIdle = 1'b0, StReq = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [AddrWidth-1:0]   pc_q, pc_d;
  logic                   stale_q, stale_d;
  logic [CntW-1:0]        out_q, out_d;
  logic [CntW-1:0]        disc_q, disc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        wptr_q, wptr_d;
  logic [PtrW-1:0]        rptr_q, rptr_d;
  logic [AqPtrW-1:0]      aq_wr_q, aq_wr_d;
  logic [AqPtrW-1:0]      aq_rd_q, aq_rd_d;
  logic [DataWidth-1:0]   data_q  [FifoDepth];
  logic [AddrWidth-1:0]   faddr_q [FifoDepth];
  logic [AddrWidth-1:0]   aq_q    [MaxOutstanding];

  logic                   w_grant, w_rsp, w_drop, w_accept, w_push, w_pop;
  logic                   w_issue_now, w_issue_post;
  logic [AddrWidth-1:0]   w_rsp_addr;

  assign instr_req_o  = (state_q == StReq);
  assign instr_addr_o = addr_q;
  assign busy_o       = instr_req_o | (out_q != '0);

  assign w_grant    = instr_req_o & instr_ready_i;
  assign w_rsp      = instr_valid_i;
  // Flush wins over a same-cycle response, so that word is dropped as well.
  assign w_drop     = flush_i | (disc_q != '0);
  assign w_accept   = w_rsp & ~w_drop;
  assign w_rsp_addr = aq_q[aq_rd_q];
  assign w_pop      = (cnt_q != '0) & out_ready_i & ~flush_i;

`ifdef BETA_FU_BYPASS_EN
  logic w_byp;
  assign w_byp       = w_accept & (cnt_q == '0);
  assign out_valid_o = (cnt_q != '0) | w_byp;
  assign out_instr_o = w_byp ? instr_rdata_i : data_q[rptr_q];
  assign out_addr_o  = w_byp ? w_rsp_addr    : faddr_q[rptr_q];
  assign w_push      = w_accept & ~(w_byp & out_ready_i);
`else
  assign out_valid_o = (cnt_q != '0);
  assign out_instr_o = data_q[rptr_q];
  assign out_addr_o  = faddr_q[rptr_q];
  assign w_push      = w_accept;
`endif

  always_comb begin
    out_d   = out_q + CntW'(w_grant) - CntW'(w_rsp);
    cnt_d   = flush_i ? '0 : (cnt_q + CntW'(w_push) - CntW'(w_pop));
    rptr_d  = rptr_q + PtrW'(w_pop);
    wptr_d  = flush_i ? rptr_q : (wptr_q + PtrW'(w_push));
    aq_wr_d = w_grant ? ((aq_wr_q == AqLast) ? '0 : aq_wr_q + 1'b1) : aq_wr_q;
    aq_rd_d = w_rsp   ? ((aq_rd_q == AqLast) ? '0 : aq_rd_q + 1'b1) : aq_rd_q;
    // Everything still in flight after this cycle belongs to the old stream.
    if (flush_i) begin
      disc_d = out_d;
    end else begin
      disc_d = disc_q - CntW'(w_rsp & (disc_q != '0)) + CntW'(w_grant & stale_q);
    end
  end

  assign w_issue_now  = fetch_en_i & ~flush_i & (out_q < MaxOut) &
                        ((SumW'(cnt_q) + SumW'(out_q)) < DepthSum);
  assign w_issue_post = fetch_en_i & ~flush_i & (out_d < MaxOut) &
                        ((SumW'(cnt_d) + SumW'(out_d)) < DepthSum);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    if (flush_i) begin
      pc_d = flush_addr_i;
    end else if (w_grant & ~stale_q) begin
      pc_d = pc_q + PcStep;
    end
    case (state_q)
      StIdle: begin
        if (w_issue_now) begin
          state_d = StReq;
          addr_d  = pc_q;
        end
      end
      StReq: begin
        if (w_grant) begin
          stale_d = 1'b0;
          if (w_issue_post) begin
            addr_d = pc_d;
          end else begin
            state_d = StIdle;
          end
        end else if (flush_i) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= BootAddr;
      pc_q    <= BootAddr;
      stale_q <= 1'b0;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        data_q[i]  <= '0;
        faddr_q[i] <= BootAddr;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      if (w_push) begin
        data_q[wptr_q]  <= instr_rdata_i;
        faddr_q[wptr_q] <= w_rsp_addr;
      end
    end
  end

  // Granted-address queue; entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (w_grant) begin
      aq_q[aq_wr_q] <= addr_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_beta_prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_prefetch_fetch_unit
// Brief    : Randomized self-checking bench with an in-order imem model and a
//            stream-level reference for beta_prefetch_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_prefetch_fetch_unit;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          DEP  = 4;
  localparam int          MAXO = 2;
  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_en_i, flush_i, instr_req_o, instr_ready_i, instr_valid_i;
  logic          out_valid_o, out_ready_i, busy_o;
  logic [AW-1:0] flush_addr_i, instr_addr_o, out_addr_o;
  logic [DW-1:0] instr_rdata_i, out_instr_o;

  always #5 clk = ~clk;

  beta_prefetch_fetch_unit #(
    .DataWidth(DW), .AddrWidth(AW), .FifoDepth(DEP), .MaxOutstanding(MAXO), .BootAddr(BOOT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en_i), .flush_i(flush_i),
    .flush_addr_i(flush_addr_i), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_ready_i(instr_ready_i), .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
    .out_addr_o(out_addr_o), .busy_o(busy_o)
  );

  int          tests = 0;
  int          fails = 0;
  int unsigned rdy_pct = 100;
  int unsigned rsp_pct = 100;
  int          grant_cnt = 0;
  int          pop_cnt = 0;

  logic [31:0] q[$];
  logic [31:0] exp_req, pop_exp, addr_prev;
  bit          stale, pend_prev, flush_prev;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // In-order imem: random grant readiness and random response delay (>=1 cycle).
  initial begin
    instr_ready_i = 1'b0;
    instr_valid_i = 1'b0;
    instr_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      instr_ready_i = ($urandom_range(99) < rdy_pct);
      if (!rst && q.size() != 0 && $urandom_range(99) < rsp_pct) begin
        instr_valid_i = 1'b1;
        instr_rdata_i = mem(q[0]);
      end else begin
        instr_valid_i = 1'b0;
        instr_rdata_i = $urandom;
      end
    end
  end

  // Stream reference: sequential request/delivery addresses restarting at each flush target.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_req    = BOOT;
      pop_exp    = BOOT;
      stale      = 1'b0;
      pend_prev  = 1'b0;
      flush_prev = 1'b0;
    end else begin
      if (pend_prev) begin
        tests++;
        if (!instr_req_o || instr_addr_o !== addr_prev) begin
          fails++;
          $display("FAIL req_stable: req=%b addr=%h want req=1 addr=%h", instr_req_o, instr_addr_o, addr_prev);
        end
      end
      tests++;
      if (busy_o !== (instr_req_o || q.size() != 0)) begin
        fails++;
        $display("FAIL busy: got %b want %b", busy_o, (instr_req_o || q.size() != 0));
      end
      if (flush_prev) begin
        tests++;
        if (out_valid_o !== 1'b0) begin
          fails++;
          $display("FAIL valid_after_flush: got %b want 0", out_valid_o);
        end
      end
      if (instr_valid_i) void'(q.pop_front());
      if (instr_req_o && instr_ready_i) begin
        grant_cnt++;
        if (stale) begin
          stale = 1'b0;
        end else begin
          tests++;
          if (instr_addr_o !== exp_req) begin
            fails++;
            $display("FAIL req_addr: got %h want %h", instr_addr_o, exp_req);
          end
          exp_req = exp_req + 32'd4;
        end
        q.push_back(instr_addr_o);
      end
      tests++;
      if (q.size() > MAXO) begin
        fails++;
        $display("FAIL outstanding: got %0d want <= %0d", q.size(), MAXO);
      end
      if (out_valid_o && out_ready_i && !flush_i) begin
        pop_cnt++;
        tests++;
        if (out_addr_o !== pop_exp || out_instr_o !== mem(pop_exp)) begin
          fails++;
          $display("FAIL pop: got addr=%h instr=%h want addr=%h instr=%h",
                   out_addr_o, out_instr_o, pop_exp, mem(pop_exp));
        end
        pop_exp = pop_exp + 32'd4;
      end
      if (flush_i) begin
        stale   = instr_req_o && !instr_ready_i ? 1'b1 : stale;
        if (instr_req_o && instr_ready_i) stale = 1'b0;
        exp_req = flush_addr_i;
        pop_exp = flush_addr_i;
      end
      pend_prev  = instr_req_o && !instr_ready_i;
      addr_prev  = instr_addr_o;
      flush_prev = flush_i;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0; flush_addr_i = '0;
    rdy_pct = 100; rsp_pct = 100;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_pop(input string name, output logic [31:0] a, output logic [31:0] d);
    int n = 0;
    a = 'x; d = 'x;
    @(negedge clk);
    while (!(out_valid_o && out_ready_i) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL %s: no output within 50 cycles", name);
    end else begin
      a = out_addr_o; d = out_instr_o;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fetch_en_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0; flush_addr_i = '0;
    tick();
    tests += 6;
    if (instr_req_o !== 1'b0)  begin fails++; $display("FAIL rst_req: got %b want 0", instr_req_o); end
    if (instr_addr_o !== BOOT) begin fails++; $display("FAIL rst_addr: got %h want %h", instr_addr_o, BOOT); end
    if (out_valid_o !== 1'b0)  begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid_o); end
    if (out_instr_o !== '0)    begin fails++; $display("FAIL rst_instr: got %h want 0", out_instr_o); end
    if (out_addr_o !== BOOT)   begin fails++; $display("FAIL rst_oaddr: got %h want %h", out_addr_o, BOOT); end
    if (busy_o !== 1'b0)       begin fails++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int n = 0;
    int p0;
    do_reset();
    out_ready_i = 1'b1; fetch_en_i = 1'b1;
    while (!instr_req_o && n < 10) begin tick(); n++; end
    tests++;
    if (!instr_req_o || instr_addr_o !== BOOT) begin
      fails++; $display("FAIL lat_req: req=%b addr=%h want req=1 addr=%h", instr_req_o, instr_addr_o, BOOT);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
`ifdef BETA_FU_BYPASS_EN
    if (out_valid_o !== 1'b1 || out_addr_o !== BOOT) begin
      fails++; $display("FAIL lat_n1: valid=%b addr=%h want 1 %h", out_valid_o, out_addr_o, BOOT);
    end
`else
    if (out_valid_o !== 1'b0) begin
      fails++; $display("FAIL lat_n1: valid=%b want 0", out_valid_o);
    end
`endif
    @(negedge clk);
    tests++;
`ifdef BETA_FU_BYPASS_EN
    if (out_valid_o !== 1'b1 || out_addr_o !== BOOT + 32'd4) begin
      fails++; $display("FAIL lat_n2: valid=%b addr=%h want 1 %h", out_valid_o, out_addr_o, BOOT + 32'd4);
    end
`else
    if (out_valid_o !== 1'b1 || out_addr_o !== BOOT) begin
      fails++; $display("FAIL lat_n2: valid=%b addr=%h want 1 %h", out_valid_o, out_addr_o, BOOT);
    end
`endif
    #1;
    p0 = pop_cnt;
    repeat (16) @(negedge clk);
    #1;
    tests++;
    if (pop_cnt - p0 != 16) begin
      fails++; $display("FAIL throughput: got %0d pops want 16", pop_cnt - p0);
    end
  endtask

  task automatic test_credit_limit();
    int g0;
    do_reset();
    g0 = grant_cnt;
    fetch_en_i = 1'b1;
    repeat (12) tick();
    tests += 3;
    if (grant_cnt - g0 != DEP) begin fails++; $display("FAIL full_grants: got %0d want %0d", grant_cnt - g0, DEP); end
    if (instr_req_o !== 1'b0)  begin fails++; $display("FAIL full_req: got %b want 0", instr_req_o); end
    if (out_valid_o !== 1'b1 || out_addr_o !== BOOT) begin
      fails++; $display("FAIL full_head: valid=%b addr=%h want 1 %h", out_valid_o, out_addr_o, BOOT);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    g0 = grant_cnt;
    repeat (10) tick();
    tests += 2;
    if (grant_cnt - g0 != 1)  begin fails++; $display("FAIL refill_grants: got %0d want 1", grant_cnt - g0); end
    if (instr_req_o !== 1'b0) begin fails++; $display("FAIL refill_req: got %b want 0", instr_req_o); end
  endtask

  task automatic test_ready_stall();
    int n = 0;
    int g0;
    logic [31:0] a, d;
    do_reset();
    out_ready_i = 1'b1; rdy_pct = 0;
    fetch_en_i = 1'b1; flush_i = 1'b1; flush_addr_i = 32'h10;
    tick();
    flush_i = 1'b0;
    while (!instr_req_o && n < 10) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h10) begin
        fails++; $display("FAIL stall_hold%0d: req=%b addr=%h want 1 00000010", i, instr_req_o, instr_addr_o);
      end
      tick();
    end
    g0 = grant_cnt;
    rdy_pct = 100;
    tick();
    tests++;
    if (grant_cnt - g0 != 1) begin fails++; $display("FAIL stall_grant: got %0d grants want 1", grant_cnt - g0); end
    wait_pop("stall_pop", a, d);
    tests++;
    if (a !== 32'h10 || d !== mem(32'h10)) begin
      fails++; $display("FAIL stall_first: got %h/%h want 00000010/%h", a, d, mem(32'h10));
    end
  endtask

  task automatic test_flush_outstanding();
    logic [31:0] a, d;
    do_reset();
    out_ready_i = 1'b1; rsp_pct = 0; fetch_en_i = 1'b1;
    repeat (6) tick();
    tests++;
    if (q.size() != 2 || busy_o !== 1'b1) begin
      fails++; $display("FAIL fl_setup: outstanding=%0d busy=%b want 2 1", q.size(), busy_o);
    end
    flush_i = 1'b1; flush_addr_i = 32'h100;
    tick();
    flush_i = 1'b0; rsp_pct = 100;
    wait_pop("fl_pop", a, d);
    tests++;
    if (a !== 32'h100 || d !== mem(32'h100)) begin
      fails++; $display("FAIL fl_first: got %h/%h want 00000100/%h", a, d, mem(32'h100));
    end
  endtask

  task automatic test_flush_pop_rvalid();
    logic [31:0] a, d;
    do_reset();
    fetch_en_i = 1'b1;
    repeat (10) tick();
    rsp_pct = 0; out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    repeat (4) tick();
    tests++;
    if (q.size() != 1 || out_valid_o !== 1'b1) begin
      fails++; $display("FAIL fpr_setup: outstanding=%0d valid=%b want 1 1", q.size(), out_valid_o);
    end
    flush_i = 1'b1; flush_addr_i = 32'h200; out_ready_i = 1'b1; rsp_pct = 100;
    @(negedge clk);
    tests++;
    if (instr_valid_i !== 1'b1 || out_valid_o !== 1'b1) begin
      fails++; $display("FAIL fpr_same: rvalid=%b valid=%b want 1 1", instr_valid_i, out_valid_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid_o !== 1'b0) begin fails++; $display("FAIL fpr_empty: valid=%b want 0", out_valid_o); end
    #1;
    out_ready_i = 1'b1;
    wait_pop("fpr_pop", a, d);
    tests++;
    if (a !== 32'h200 || d !== mem(32'h200)) begin
      fails++; $display("FAIL fpr_first: got %h/%h want 00000200/%h", a, d, mem(32'h200));
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] a, d;
    logic [31:0] seen [4];
    do_reset();
    out_ready_i = 1'b1; fetch_en_i = 1'b1;
    flush_i = 1'b1; flush_addr_i = 32'hFFFF_FFF8;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_pop("wrap_pop", a, d);
      seen[i] = a;
    end
    tests++;
    if (seen[2] !== 32'h0 || seen[3] !== 32'h4) begin
      fails++; $display("FAIL wrap: got %h %h want 00000000 00000004", seen[2], seen[3]);
    end
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    rdy_pct = 70; rsp_pct = 60;
    p0 = pop_cnt;
    for (int i = 0; i < 800; i++) begin
      fetch_en_i   = ($urandom_range(99) < 90);
      out_ready_i  = ($urandom_range(99) < 70);
      flush_i      = ($urandom_range(99) < 3);
      flush_addr_i = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    tests++;
    if (pop_cnt - p0 < 100) begin fails++; $display("FAIL rand_progress: got %0d pops want >= 100", pop_cnt - p0); end
    flush_i = 1'b0; fetch_en_i = 1'b1; out_ready_i = 1'b1; rdy_pct = 100; rsp_pct = 100;
    repeat (6) tick();
    p0 = pop_cnt;
    repeat (20) tick();
    tests++;
    if (pop_cnt - p0 < 19) begin fails++; $display("FAIL rand_drain: got %0d pops want >= 19", pop_cnt - p0); end
  endtask

  task automatic test_async_reset();
    logic [31:0] a, d;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if (instr_req_o !== 1'b0 || out_valid_o !== 1'b0 || busy_o !== 1'b0 || instr_addr_o !== BOOT) begin
      fails++; $display("FAIL async_rst: req=%b valid=%b busy=%b addr=%h want 0 0 0 %h",
                        instr_req_o, out_valid_o, busy_o, instr_addr_o, BOOT);
    end
    repeat (2) tick();
    rst = 1'b0;
    wait_pop("arst_pop", a, d);
    tests++;
    if (a !== BOOT || d !== mem(BOOT)) begin
      fails++; $display("FAIL arst_restart: got %h/%h want %h/%h", a, d, BOOT, mem(BOOT));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_credit_limit();
    test_ready_stall();
    test_flush_outstanding();
    test_flush_pop_rvalid();
    test_pc_wrap();
    test_random();
    test_async_reset();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
